// File: rtl/keccak_padder_gen.sv
// Packs W-bit big-endian words into RATE-bit blocks with pad10*1 padding; block valid one edge after slot N fills.
// buffer_full is high while padding, presenting a block or done; blocks are held until f_ack.
// KECCAK_SHA3_PAD_EN selects the SHA-3 domain pad byte 0x06 instead of the Keccak pad byte 0x01.
module keccak_padder_gen #(
    parameter int W    = 32,
    parameter int RATE = 576
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [W-1:0]           in,
    input  logic                   in_ready,
    input  logic                   is_last,
    input  logic [$clog2(W/8)-1:0] byte_num,
    output logic                   buffer_full,
    output logic [RATE-1:0]        out,
    output logic                   out_ready,
    output logic                   out_last,
    input  logic                   f_ack
);

    localparam int N  = RATE / W;
    localparam int NB = W / 8;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_ABSORB = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          final_slot;
    logic [W-1:0]  end_word;
    logic [W-1:0]  last_word;

    // The word written this cycle lands in slot N, so it carries the closing 0x80 bit.
    assign final_slot  = (cnt == CW'(N - 1));
    assign end_word    = final_slot ? W'(8'h80) : '0;
    assign buffer_full = (state != ST_ABSORB);
    assign out_ready   = (state == ST_FULL);

    always_comb begin
        last_word = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(byte_num))
                last_word[W-1-8*j -: 8] = in[W-1-8*j -: 8];
            else if (j == int'(byte_num))
                last_word[W-1-8*j -: 8] = PAD_BYTE;
        end
        last_word = last_word | end_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_ABSORB;
            cnt      <= '0;
            out      <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                ST_ABSORB: begin
                    if (in_ready) begin
                        out <= {out[RATE-W-1:0], is_last ? last_word : in};
                        cnt <= cnt + CW'(1);
                        if (is_last) begin
                            out_last <= final_slot;
                            state    <= final_slot ? ST_FULL : ST_PAD;
                        end else if (final_slot) begin
                            out_last <= 1'b0;
                            state    <= ST_FULL;
                        end
                    end
                end
                ST_PAD: begin
                    out <= {out[RATE-W-1:0], end_word};
                    cnt <= cnt + CW'(1);
                    if (final_slot) begin
                        out_last <= 1'b1;
                        state    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (f_ack) begin
                        if (out_last) begin
                            state <= ST_DONE;
                        end else begin
                            cnt   <= '0;
                            state <= ST_ABSORB;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
